// File: rtl/sdram_memtest_if.sv
// Command/response channel between the memory test generator and the SDRAM controller.
// Responses return in command order, one word per rsp_vld.
interface sdram_memtest_if #(
    parameter int AW = 22
);
    logic          cmd_vld;
    logic          cmd_rdy;
    logic          cmd_we;
    logic [AW-1:0] cmd_adr;
    logic [15:0]   cmd_wdt;
    logic          rsp_vld;
    logic [15:0]   rsp_rdt;

    modport master (
        output cmd_vld, cmd_we, cmd_adr, cmd_wdt,
        input  cmd_rdy, rsp_vld, rsp_rdt
    );

    modport slave (
        input  cmd_vld, cmd_we, cmd_adr, cmd_wdt,
        output cmd_rdy, rsp_vld, rsp_rdt
    );
endinterface

// File: rtl/sdram_memtest.sv
// SDRAM bring-up traffic generator: writes an LFSR pattern over 0..ADR_LAST, reads it back
// with up to MAX_OUT reads in flight, and reports pass/fail with the first failing address.
module sdram_memtest #(
    parameter int          AW       = 22,
    parameter int unsigned ADR_LAST = (32'd1 << AW) - 32'd1,
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter int          MAX_OUT  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic [15:0]          err_cnt,
    output logic [AW-1:0]        err_adr,
    sdram_memtest_if.master      bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [AW-1:0] LAST    = AW'(ADR_LAST);
    localparam logic [3:0]    OUT_MAX = 4'(MAX_OUT);
    localparam logic [15:0]   POLY    = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? POLY : 16'h0000);
    endfunction

    logic [2:0]    state;
    logic [AW-1:0] wadr;
    logic [AW-1:0] adr;
    logic [AW-1:0] radr;
    logic [3:0]    outstanding;
    logic [15:0]   gen;
    logic [15:0]   chk;

    logic          accept;
    logic          rsp_ok;
    logic          mismatch;
    logic [3:0]    out_next;
    logic [15:0]   err_next;

    // Responses outside READ/DRAIN or with nothing in flight are protocol violations and ignored.
    always_comb begin
        accept   = bus.cmd_vld & bus.cmd_rdy;
        rsp_ok   = bus.rsp_vld && (outstanding != 4'd0) &&
                   ((state == S_READ) || (state == S_DRAIN));
        mismatch = rsp_ok && (bus.rsp_rdt != chk);
        out_next = outstanding;
        if ((state == S_READ) && accept) begin
            out_next = out_next + 4'd1;
        end
        if (rsp_ok) begin
            out_next = out_next - 4'd1;
        end
        err_next = err_cnt;
        if (mismatch && (err_cnt != 16'hFFFF)) begin
            err_next = err_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wadr        <= '0;
            adr         <= '0;
            radr        <= '0;
            outstanding <= 4'd0;
            gen         <= SEED;
            chk         <= SEED;
            err_cnt     <= 16'd0;
            err_adr     <= '0;
            fail        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            bus.cmd_vld <= 1'b0;
            bus.cmd_we  <= 1'b0;
            bus.cmd_adr <= '0;
            bus.cmd_wdt <= 16'd0;
        end else begin
            err_cnt     <= err_next;
            outstanding <= out_next;
            if (rsp_ok) begin
                chk  <= lfsr_step(chk);
                radr <= radr + 1'b1;
            end
            if (mismatch) begin
                fail <= 1'b1;
                if (!fail) begin
                    err_adr <= radr;
                end
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_WRITE;
                        err_cnt     <= 16'd0;
                        err_adr     <= '0;
                        fail        <= 1'b0;
                        gen         <= SEED;
                        chk         <= SEED;
                        wadr        <= '0;
                        adr         <= '0;
                        radr        <= '0;
                        outstanding <= 4'd0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        bus.cmd_vld <= 1'b1;
                        bus.cmd_we  <= 1'b1;
                        bus.cmd_adr <= '0;
                        bus.cmd_wdt <= SEED;
                    end
                end

                // Payload is the next word's address/pattern so accepts can stream every cycle.
                S_WRITE: begin
                    if (accept) begin
                        gen  <= lfsr_step(gen);
                        wadr <= wadr + 1'b1;
                        if (wadr == LAST) begin
                            state       <= S_READ;
                            bus.cmd_we  <= 1'b0;
                            bus.cmd_adr <= '0;
                            bus.cmd_wdt <= 16'd0;
                        end else begin
                            bus.cmd_adr <= wadr + 1'b1;
                            bus.cmd_wdt <= lfsr_step(gen);
                        end
                    end
                end

                S_READ: begin
                    if (accept) begin
                        adr <= adr + 1'b1;
                        if (adr == LAST) begin
                            state       <= S_DRAIN;
                            bus.cmd_vld <= 1'b0;
                            bus.cmd_adr <= '0;
                        end else begin
                            bus.cmd_vld <= (out_next < OUT_MAX);
                            bus.cmd_adr <= adr + 1'b1;
                        end
                    end else begin
                        bus.cmd_vld <= (out_next < OUT_MAX);
                    end
                end

                // pass uses err_next so a mismatch on the final response is not missed.
                S_DRAIN: begin
                    if (out_next == 4'd0) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == 16'd0);
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_memtest.sv
// Randomised bench for sdram_memtest: a memory-model responder, a scoreboard fed by the
// stimulus tasks and a monitor that checks commands, responses and end-of-run results.
module tb_sdram_memtest;

    localparam int          AW   = 4;
    localparam int          NW   = 16;
    localparam int          MAXO = 4;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          pass;
    logic          fail;
    logic [15:0]   err_cnt;
    logic [AW-1:0] err_adr;

    sdram_memtest_if #(.AW(AW)) bus ();

    sdram_memtest #(
        .AW       (AW),
        .ADR_LAST (NW - 1),
        .SEED     (SEED),
        .MAX_OUT  (MAXO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .fail    (fail),
        .err_cnt (err_cnt),
        .err_adr (err_adr),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    // Reference pattern: word i holds the seed advanced i times by the right-shifting Galois LFSR.
    function automatic logic [15:0] pattern(input int i);
        logic [15:0] x;
        x = SEED;
        for (int k = 0; k < i; k++) begin
            x = x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
        end
        return x;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic          we;
        logic [AW-1:0] adr;
        logic [15:0]   wdt;
    } cmd_t;

    typedef struct packed {
        logic [15:0]   cnt;
        logic [AW-1:0] adr;
        logic          pass;
    } res_t;

    cmd_t exp_cmd_q[$];
    int   exp_rd_q[$];
    res_t exp_res_q[$];

    int   lat         = 3;
    bit   rdy_rand    = 1'b0;
    int   corrupt_adr = -1;
    bit   invert_all  = 1'b0;
    int   drop_cnt    = 0;

    logic [15:0] mem [NW];
    int          rd_adr_q[$];
    int          rd_due_q[$];

    // Responder: memory model with fixed read latency, optional random back-pressure and corruption.
    initial begin
        int          a;
        logic [15:0] d;
        bus.cmd_rdy = 1'b0;
        bus.rsp_vld = 1'b0;
        bus.rsp_rdt = 16'd0;
        forever begin
            @(negedge clk);
            if (!rst && bus.cmd_vld && bus.cmd_rdy) begin
                if (bus.cmd_we) begin
                    mem[bus.cmd_adr] = bus.cmd_wdt;
                end else begin
                    rd_adr_q.push_back(int'(bus.cmd_adr));
                    rd_due_q.push_back(cyc + 1 + lat);
                end
            end
            @(posedge clk);
            #2;
            bus.cmd_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rd_due_q.size() > 0 && rd_due_q[0] <= cyc) begin
                a = rd_adr_q.pop_front();
                void'(rd_due_q.pop_front());
                d = mem[a];
                if (invert_all) d = ~d;
                else if (a == corrupt_adr) d[0] = ~d[0];
                bus.rsp_vld = 1'b1;
                bus.rsp_rdt = d;
            end else begin
                bus.rsp_vld = 1'b0;
                bus.rsp_rdt = 16'd0;
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted command, every response and every DONE entry.
    initial begin
        int            mon_out;
        int            mon_mis;
        int            mon_first_adr;
        int            a;
        bit            chk_fail_next;
        bit            prev_stall;
        bit            prev_done;
        logic          prev_we;
        logic [AW-1:0] prev_adr;
        logic [15:0]   prev_wdt;
        cmd_t          e;
        res_t          r;
        mon_out = 0; mon_mis = 0; mon_first_adr = 0;
        chk_fail_next = 0; prev_stall = 0; prev_done = 0;
        prev_we = 0; prev_adr = '0; prev_wdt = 16'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_out = 0; mon_mis = 0;
                chk_fail_next = 0; prev_stall = 0; prev_done = 0;
            end else begin
                if (start && !busy) begin
                    mon_out = 0; mon_mis = 0; chk_fail_next = 0;
                end
                if (chk_fail_next) begin
                    checkOutput("fail_after_first_mismatch", fail, 1);
                    checkOutput("err_adr_first", err_adr, mon_first_adr);
                    chk_fail_next = 0;
                end
                if (prev_stall) begin
                    checkOutput("stall_vld_hold", bus.cmd_vld, 1);
                    checkOutput("stall_we_hold", bus.cmd_we, prev_we);
                    checkOutput("stall_adr_hold", bus.cmd_adr, prev_adr);
                    checkOutput("stall_wdt_hold", bus.cmd_wdt, prev_wdt);
                end
                if (busy && exp_cmd_q.size() > 0 && !exp_cmd_q[0].we) begin
                    checkOutput("read_vld_rule", bus.cmd_vld, mon_out < MAXO);
                    if (!bus.cmd_vld && mon_out == MAXO) drop_cnt++;
                end
                if (bus.cmd_vld && bus.cmd_rdy) begin
                    checkOutput("cmd_expected", exp_cmd_q.size() > 0, 1);
                    if (exp_cmd_q.size() > 0) begin
                        e = exp_cmd_q.pop_front();
                        checkOutput("cmd_we", bus.cmd_we, e.we);
                        checkOutput("cmd_adr", bus.cmd_adr, e.adr);
                        checkOutput("cmd_wdt", bus.cmd_wdt, e.wdt);
                    end
                    if (!bus.cmd_we) begin
                        checkOutput("outstanding_limit", mon_out < MAXO, 1);
                        mon_out++;
                    end
                end
                if (bus.rsp_vld) begin
                    checkOutput("rsp_expected", exp_rd_q.size() > 0, 1);
                    checkOutput("fail_running", fail, mon_mis > 0);
                    checkOutput("err_cnt_running", err_cnt, mon_mis);
                    if (exp_rd_q.size() > 0) begin
                        a = exp_rd_q.pop_front();
                        if (bus.rsp_rdt != pattern(a)) begin
                            mon_mis++;
                            if (mon_mis == 1) begin
                                mon_first_adr = a;
                                chk_fail_next = 1;
                            end
                        end
                    end
                    mon_out--;
                end
                if (done && !prev_done) begin
                    checkOutput("result_expected", exp_res_q.size() > 0, 1);
                    if (exp_res_q.size() > 0) begin
                        r = exp_res_q.pop_front();
                        checkOutput("done_err_cnt", err_cnt, r.cnt);
                        checkOutput("done_err_adr", err_adr, r.adr);
                        checkOutput("done_pass", pass, r.pass);
                        checkOutput("done_fail", fail, !r.pass);
                        checkOutput("done_busy", busy, 0);
                    end
                    checkOutput("done_cmds_left", exp_cmd_q.size(), 0);
                    checkOutput("done_rsps_left", exp_rd_q.size(), 0);
                end
                prev_done  = done;
                prev_stall = bus.cmd_vld && !bus.cmd_rdy;
                prev_we    = bus.cmd_we;
                prev_adr   = bus.cmd_adr;
                prev_wdt   = bus.cmd_wdt;
            end
        end
    end

    task automatic waitDone(input string name);
        int n;
        n = 0;
        while (!done && n < 3000) begin
            @(posedge clk);
            #3;
            n++;
        end
        checkOutput(name, done, 1);
        repeat (3) begin
            @(posedge clk);
            #3;
        end
    endtask

    // One run: configure the responder, queue the expected traffic and outcome, then pulse start.
    task automatic applyStimulus(input int lat_i, input bit rdy_i, input int corrupt_i,
                                 input bit invert_i, input bit wait_done);
        res_t r;
        int   n_err;
        lat         = lat_i;
        rdy_rand    = rdy_i;
        corrupt_adr = corrupt_i;
        invert_all  = invert_i;
        for (int i = 0; i < NW; i++) exp_cmd_q.push_back({1'b1, AW'(i), pattern(i)});
        for (int i = 0; i < NW; i++) exp_cmd_q.push_back({1'b0, AW'(i), 16'd0});
        for (int i = 0; i < NW; i++) exp_rd_q.push_back(i);
        n_err  = invert_i ? NW : ((corrupt_i >= 0 && corrupt_i < NW) ? 1 : 0);
        r.cnt  = 16'(n_err);
        r.adr  = invert_i ? '0 : ((n_err > 0) ? AW'(corrupt_i) : '0);
        r.pass = (n_err == 0);
        exp_res_q.push_back(r);
        start = 1'b1;
        @(posedge clk);
        #3;
        start = 1'b0;
        checkOutput("start_busy", busy, 1);
        checkOutput("start_done", done, 0);
        checkOutput("start_pass", pass, 0);
        checkOutput("start_fail", fail, 0);
        checkOutput("start_err_cnt", err_cnt, 0);
        checkOutput("start_cmd_vld", bus.cmd_vld, 1);
        checkOutput("start_cmd_wdt", bus.cmd_wdt, SEED);
        if (wait_done) waitDone("done_reached");
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_pass"}, pass, 0);
        checkOutput({tag, "_fail"}, fail, 0);
        checkOutput({tag, "_err_cnt"}, err_cnt, 0);
        checkOutput({tag, "_err_adr"}, err_adr, 0);
        checkOutput({tag, "_cmd_vld"}, bus.cmd_vld, 0);
        checkOutput({tag, "_cmd_we"}, bus.cmd_we, 0);
        checkOutput({tag, "_cmd_adr"}, bus.cmd_adr, 0);
        checkOutput({tag, "_cmd_wdt"}, bus.cmd_wdt, 0);
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        checkAllZero("reset");
        rst = 1'b0;
        @(posedge clk);
        #3;

        $display("[TB] clean run, latency 3");
        applyStimulus(3, 1'b0, -1, 1'b0, 1'b1);

        $display("[TB] corrupted read at address 5");
        applyStimulus(3, 1'b0, 5, 1'b0, 1'b1);

        $display("[TB] random back-pressure");
        applyStimulus(3, 1'b1, -1, 1'b0, 1'b1);

        $display("[TB] latency 10, outstanding limit");
        drop_cnt = 0;
        applyStimulus(10, 1'b0, -1, 1'b0, 1'b1);
        checkOutput("vld_drop_at_limit", drop_cnt > 0, 1);

        $display("[TB] reset during read phase");
        applyStimulus(3, 1'b0, -1, 1'b0, 1'b0);
        n = 0;
        while (exp_cmd_q.size() > NW - 4 && n < 500) begin
            @(posedge clk);
            #3;
            n++;
        end
        checkOutput("reached_read_phase", exp_cmd_q.size() <= NW - 4, 1);
        rst = 1'b1;
        exp_cmd_q.delete();
        exp_rd_q.delete();
        exp_res_q.delete();
        rd_adr_q.delete();
        rd_due_q.delete();
        @(posedge clk);
        #3;
        checkAllZero("midrst");
        rst = 1'b0;
        @(posedge clk);
        #3;
        applyStimulus(3, 1'b0, -1, 1'b0, 1'b1);

        $display("[TB] all reads inverted, then restart from DONE");
        applyStimulus(3, 1'b0, -1, 1'b1, 1'b1);
        applyStimulus(3, 1'b1, -1, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
